// File: rtl/dmem_pkg.sv
// Shared types for the data-port arbiter of the unified instruction/data RAM.
package dmem_pkg;

   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } dmem_req_t;

   localparam int DMEM_RD_LAT = 1;

   typedef enum logic {PORT_CORE, PORT_DBG} dmem_port_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the port that did not win most recently.
module rr_pick2
   import dmem_pkg::*;
(
   input  logic       req0,
   input  logic       req1,
   input  dmem_port_e last,
   output logic       gnt0,
   output logic       gnt1
);

   always_comb begin
      gnt0 = req0 & (~req1 | (last == PORT_DBG));
      gnt1 = req1 & (~req0 | (last == PORT_CORE));
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the RAM data port between the core LSU (port 0) and the debug
// loader (port 1), with bounded port-1 locking and one-cycle response routing.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_LOCK = 16,
   parameter int ADDR_W   = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [3:0]        m0_be,
   input  logic [31:0]       m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [3:0]        m1_be,
   input  logic [31:0]       m1_wdata,
   input  logic              m1_lock,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [31:0]       m0_rdata,
   output logic [31:0]       m1_rdata,
   output logic [ADDR_W-1:0] d_addr,
   output logic              d_we,
   output logic [3:0]        d_be,
   output logic [31:0]       d_wdata,
   input  logic [31:0]       d_rdata
);

   localparam int              CNT_W   = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   dmem_port_e       last;
   logic [CNT_W-1:0] lock_cnt;
   logic             pend_vld;
   dmem_port_e       pend_id;
   logic             pend_we;

   logic             rr_gnt0, rr_gnt1;
   logic             lock_on, lock_yield;
   logic             gnt0, gnt1;
   logic             rsp;
   logic [31:0]      rsp_data;

   rr_pick2 u_pick (
      .req0 (m0_req),
      .req1 (m1_req),
      .last (last),
      .gnt0 (rr_gnt0),
      .gnt1 (rr_gnt1)
   );

   // pend_vld with pend_id==PORT_DBG means port 1 won the previous cycle
   always_comb begin
      lock_on    = pend_vld && (pend_id == PORT_DBG) && m1_lock && m1_req;
      lock_yield = lock_on && (lock_cnt == CNT_MAX) && m0_req;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      if (!rst) begin
         if (lock_on) begin
            gnt0 = lock_yield;
            gnt1 = ~lock_yield;
         end else begin
            gnt0 = rr_gnt0;
            gnt1 = rr_gnt1;
         end
      end
   end

   assign m0_gnt = gnt0;
   assign m1_gnt = gnt1;

   always_comb begin
      d_addr  = m0_addr;
      d_wdata = m0_wdata;
      d_we    = 1'b0;
      d_be    = 4'b0000;
      if (gnt1) begin
         d_addr  = m1_addr;
         d_wdata = m1_wdata;
         d_we    = m1_we;
         d_be    = m1_be;
      end else if (gnt0) begin
         d_we    = m0_we;
         d_be    = m0_be;
      end
   end

   // Arbitration state and accepted-transfer tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         last     <= PORT_DBG;
         lock_cnt <= '0;
         pend_vld <= 1'b0;
      end else begin
         pend_vld <= gnt0 | gnt1;
         if (gnt1) begin
            last <= PORT_DBG;
         end else if (gnt0) begin
            last <= PORT_CORE;
         end
         if (!gnt1) begin
            lock_cnt <= '0;
         end else if (lock_on && (lock_cnt != CNT_MAX)) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (gnt0 | gnt1) begin
         pend_id <= gnt1 ? PORT_DBG : PORT_CORE;
         pend_we <= gnt1 ? m1_we : m0_we;
      end
   end

   // The RAM leaves d_rdata stale on writes, so write acks return zero
   always_comb begin
      rsp       = pend_vld & ~rst;
      rsp_data  = pend_we ? 32'h0 : d_rdata;
      m0_rvalid = rsp && (pend_id == PORT_CORE);
      m1_rvalid = rsp && (pend_id == PORT_DBG);
      m0_rdata  = m0_rvalid ? rsp_data : 32'h0;
      m1_rdata  = m1_rvalid ? rsp_data : 32'h0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, per-cycle reference model comparison,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_arbiter;

   localparam int ML = 4;
   localparam int AW = 30;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_req = 1'b0, m0_we = 1'b0;
   logic [AW-1:0] m0_addr = '0;
   logic [3:0]    m0_be = 4'h0;
   logic [31:0]   m0_wdata = 32'h0;
   logic          m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
   logic [AW-1:0] m1_addr = '0;
   logic [3:0]    m1_be = 4'h0;
   logic [31:0]   m1_wdata = 32'h0;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [31:0]   m0_rdata, m1_rdata;
   logic [AW-1:0] d_addr;
   logic          d_we;
   logic [3:0]    d_be;
   logic [31:0]   d_wdata;
   logic [31:0]   d_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram     [0:1023];
   logic [31:0] ref_mem [0:1023];

   dmem_arbiter #(.MAX_LOCK(ML), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata)
   );

   always #5 clk = ~clk;

   // RAM data port: byte-masked write, otherwise registered read
   always @(posedge clk) begin
      if (d_we) begin
         for (int b = 0; b < 4; b++)
            if (d_be[b]) ram[d_addr[9:0]][8*b +: 8] <= d_wdata[8*b +: 8];
      end else begin
         d_rdata <= ram[d_addr[9:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model state: winner history, lock run length, one pending response
   int          mdl_last = 1;
   bit          mdl_won1 = 1'b0;
   int          mdl_run  = 0;
   bit          mdl_pend = 1'b0;
   int          mdl_pport = 0;
   logic [31:0] mdl_pdata = 32'h0;

   always @(negedge clk) begin
      int          w;
      bit          locked;
      logic        f_we;
      logic [AW-1:0] f_addr;
      logic [3:0]  f_be;
      logic [31:0] f_wd;
      if (rst) begin
         chk("rst_gnt0", m0_gnt, 0);
         chk("rst_gnt1", m1_gnt, 0);
         chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
         chk("rst_rdata", m0_rdata | m1_rdata, 0);
         chk("rst_dwe_dbe", {d_we, d_be}, 0);
         mdl_last = 1; mdl_won1 = 0; mdl_run = 0; mdl_pend = 0;
      end else begin
         chk("rvalid0", m0_rvalid, mdl_pend && mdl_pport == 0);
         chk("rvalid1", m1_rvalid, mdl_pend && mdl_pport == 1);
         chk("rdata0", m0_rdata, (mdl_pend && mdl_pport == 0) ? mdl_pdata : 32'h0);
         chk("rdata1", m1_rdata, (mdl_pend && mdl_pport == 1) ? mdl_pdata : 32'h0);
         locked = mdl_won1 && m1_lock && m1_req;
         if (locked)                w = (mdl_run == ML && m0_req) ? 0 : 1;
         else if (m0_req && m1_req) w = 1 - mdl_last;
         else if (m0_req)           w = 0;
         else if (m1_req)           w = 1;
         else                       w = -1;
         chk("gnt0", m0_gnt, w == 0);
         chk("gnt1", m1_gnt, w == 1);
         if (w == 1) begin
            f_we = m1_we; f_addr = m1_addr; f_be = m1_be; f_wd = m1_wdata;
         end else begin
            f_we = (w == 0) ? m0_we : 1'b0; f_addr = m0_addr;
            f_be = (w == 0) ? m0_be : 4'h0; f_wd = m0_wdata;
         end
         chk("d_addr", 32'(d_addr), 32'(f_addr));
         chk("d_we_be", {d_we, d_be}, {f_we, f_be});
         if (f_we) chk("d_wdata", d_wdata, f_wd);
         mdl_pend = (w >= 0);
         if (w >= 0) begin
            mdl_pport = w;
            if (f_we) begin
               mdl_pdata = 32'h0;
               for (int b = 0; b < 4; b++)
                  if (f_be[b]) ref_mem[f_addr[9:0]][8*b +: 8] = f_wd[8*b +: 8];
            end else begin
               mdl_pdata = ref_mem[f_addr[9:0]];
            end
            mdl_last = w;
         end
         if (w != 1)    mdl_run = 0;
         else if (locked && mdl_run < ML) mdl_run++;
         mdl_won1 = (w == 1);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
      m0_addr = 30'h100;
      repeat (2) next_cycle();
      rst = 1'b0;
   endtask

   task automatic put_word(input int a, input logic [31:0] v);
      ram[a] = v;
      ref_mem[a] = v;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp4 [8] = '{1, 1, 1, 1, 1, 0, 1, 1};
      bit g0, g1;
      for (int i = 0; i < 1024; i++) put_word(i, (i * 32'h01030507) ^ 32'h5A5A_A5A5);
      put_word(32'h100, 32'hDEADBEEF);

      // Port 0 reads alone
      do_reset();
      next_cycle();
      m0_req = 1; m0_we = 0; m0_addr = 30'h100; m0_be = 4'hF;
      #1; chk("t1_gnt0", m0_gnt, 1); chk("t1_gnt1", m1_gnt, 0);
      next_cycle();
      m0_req = 0;
      #1; chk("t1_rvalid0", m0_rvalid, 1); chk("t1_rdata0", m0_rdata, 32'hDEADBEEF);
      chk("t1_rvalid1", m1_rvalid, 0);

      // Continuous contention alternates starting with port 0
      do_reset();
      for (int k = 0; k < 7; k++) begin
         next_cycle();
         m0_req = (k < 6); m0_we = 0; m0_addr = 30'(k); m0_be = 4'hF;
         m1_req = (k < 6); m1_we = 0; m1_addr = 30'(k + 8); m1_be = 4'hF;
         #1;
         if (k < 6) begin
            chk("t2_gnt0", m0_gnt, (k % 2) == 0);
            chk("t2_gnt1", m1_gnt, (k % 2) == 1);
         end
         if (k > 0) begin
            chk("t2_rvalid0", m0_rvalid, ((k - 1) % 2) == 0);
            chk("t2_rvalid1", m1_rvalid, ((k - 1) % 2) == 1);
         end
      end

      // Byte-masked write by port 1, then read-after-write by port 0
      do_reset();
      put_word(32'h40, 32'h0);
      next_cycle();
      m1_req = 1; m1_we = 1; m1_addr = 30'h40; m1_be = 4'b0101; m1_wdata = 32'hAABBCCDD;
      #1; chk("t3_gnt1", m1_gnt, 1);
      next_cycle();
      m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 30'h40; m0_be = 4'hF;
      #1; chk("t3_wack", m1_rvalid, 1); chk("t3_wack_rdata", m1_rdata, 0);
      chk("t3_gnt0", m0_gnt, 1);
      next_cycle();
      m0_req = 0;
      #1; chk("t3_rvalid0", m0_rvalid, 1); chk("t3_raw_rdata", m0_rdata, 32'h00BB00DD);

      // Locked port 1 yields once after MAX_LOCK locked beats
      do_reset();
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 30'(k + 16); m1_be = 4'hF;
         m0_req = (k > 0); m0_we = 0; m0_addr = 30'(k + 32); m0_be = 4'hF;
         #1; chk("t4_gnt1", m1_gnt, exp4[k]); chk("t4_gnt0", m0_gnt, exp4[k] == 0);
      end
      next_cycle();
      m0_req = 0; m1_req = 0; m1_lock = 0;

      // Reset right after an accepted read suppresses its response
      do_reset();
      next_cycle();
      m0_req = 1; m0_we = 0; m0_addr = 30'h100; m0_be = 4'hF;
      #1; chk("t5_gnt0", m0_gnt, 1);
      next_cycle();
      rst = 1; m1_req = 1; m1_we = 0; m1_addr = 30'h5;
      #1; chk("t5_no_rvalid", m0_rvalid, 0); chk("t5_gnts", {m1_gnt, m0_gnt}, 0);
      next_cycle();
      #1; chk("t5_gnts_hold", {m1_gnt, m0_gnt}, 0);
      next_cycle();
      rst = 0;
      #1; chk("t5_tie_gnt0", m0_gnt, 1); chk("t5_tie_gnt1", m1_gnt, 0);
      next_cycle();
      m0_req = 0; m1_req = 0;

      // Idle cycles
      do_reset();
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         #1; chk("t6_idle_we_be", {d_we, d_be}, 0);
         chk("t6_idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
      end

      // Randomized traffic obeying the hold-until-granted rule
      do_reset();
      g0 = 0; g1 = 0;
      for (int n = 0; n < 3000; n++) begin
         next_cycle();
         rst = ($urandom_range(0, 199) == 0);
         if (!m0_req || g0) begin
            m0_req = ($urandom_range(0, 3) != 0);
            m0_we = $urandom_range(0, 1); m0_addr = 30'($urandom_range(0, 63));
            m0_be = 4'($urandom); m0_wdata = $urandom;
         end
         if (!m1_req || g1) begin
            m1_req = ($urandom_range(0, 3) != 0);
            m1_we = $urandom_range(0, 1); m1_addr = 30'($urandom_range(0, 63));
            m1_be = 4'($urandom); m1_wdata = $urandom;
         end
         m1_lock = ($urandom_range(0, 3) != 0);
         #1; g0 = m0_gnt; g1 = m1_gnt;
      end
      next_cycle();
      rst = 0; m0_req = 0; m1_req = 0; m1_lock = 0;
      repeat (3) next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data port of the unified instruction/data RAM between two requesters: port 0 is the core load/store unit and port 1 is the debug/program-loader master. The block arbitrates each cycle and drives the RAM's data-port address, write-enable, byte-enable and write-data lines. It returns read data or a write acknowledge to the winning requester one cycle after the request is accepted. It sits between the core, the loader and the RAM; the RAM's instruction port is untouched.

## Interface
- `MAX_LOCK`, default 16: maximum consecutive locked grants to port 1 while port 0 is waiting.
- `ADDR_W`, default 30: word-address width, bits [31:2].
- `clk` in 1: single clock for the block and the RAM.
- `rst` in 1: reset, synchronous and active-high.
- `m0_req`, `m1_req` in 1: request valid.
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in ADDR_W: word address.
- `m0_be`, `m1_be` in 4: byte enables; bit n covers bits [8n+7:8n].
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m1_lock` in 1: port 1 asks to keep ownership for back-to-back beats.
- `m0_gnt`, `m1_gnt` out 1: request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid` out 1: response pulse.
- `m0_rdata`, `m1_rdata` out 32: read data; 0 on a write acknowledge.
- `d_addr` out ADDR_W, `d_we` out 1, `d_be` out 4, `d_wdata` out 32: to the RAM data port.
- `d_rdata` in 32: from the RAM, valid one cycle after a read is presented.

## Operation
- Handshake: a transfer happens when `mX_req` and `mX_gnt` are both 1. The requester holds its request fields stable until it is granted. At most one grant is given per cycle.
- The RAM port is muxed combinationally from the winner. With no winner: `d_we`=0, `d_be`=0, and `d_addr`/`d_wdata` are driven from port 0.
- Round-robin:
  - Register `last` records the most recent winner and resets to 1, so port 0 wins the first tie.
  - If both ports request and no lock is in force, the port other than `last` wins.
  - If only one port requests, it wins.
- Lock:
  - Lock is in force when port 1 won last cycle and `m1_lock`=1 and `m1_req`=1 now.
  - While lock is in force, port 1 wins even if port 0 is requesting, and `lock_cnt` increments.
  - When `lock_cnt`==MAX_LOCK and `m0_req`=1, port 0 wins once and `lock_cnt` clears.
  - `lock_cnt` also clears on any cycle in which port 1 does not win.
  - Width of `lock_cnt` is $clog2(MAX_LOCK+1). It saturates and never wraps.
- Response tracking:
  - Registered `pend_vld`, `pend_id` and `pend_we` capture each accepted transfer.
  - The next cycle, `mX_rvalid` pulses for `pend_id`.
  - Read response: `mX_rdata` = `d_rdata`.
  - Write response: `mX_rdata` = 0. The RAM does not update `d_rdata` on write cycles, so its stale value must not be forwarded.
- The non-addressed port's `rdata` is 0.

## Timing
- Grant latency is 0 cycles (same cycle as the request). Response latency is exactly 1 cycle after acceptance.
- Full throughput: one accepted transfer per cycle, with back-to-back alternation allowed.
- Read-after-write to the same word on consecutive cycles returns the new data, because the RAM writes at edge N and the read is sampled at edge N+1.
- During `rst`:
  - `m0_gnt`, `m1_gnt`, `m0_rvalid`, `m1_rvalid` = 0.
  - `d_we` = 0, `d_be` = 0.
  - `pend_vld` = 0, `lock_cnt` = 0, `last` = 1.
  - `rdata` outputs = 0.
- A transfer accepted in the cycle before `rst` rises gets no `rvalid`; `rst` suppresses it.
- Requests presented while `rst`=1 are not granted.

## Structure
- Package `dmem_pkg`:
  - `typedef struct packed {logic we; logic [29:0] addr; logic [3:0] be; logic [31:0] wdata;} dmem_req_t`
  - `localparam int DMEM_RD_LAT = 1`
  - `typedef enum logic {PORT_CORE, PORT_DBG} dmem_port_e`
- One sub-module, `rr_pick2`, is natural: a combinational 2-way round-robin picker with a `last` input. Lock, counter, mux and response logic stay in `dmem_arbiter`.

## Test plan
- Port 0 reads 0x100 alone. Required: `m0_gnt`=1 in cycle 0, `m0_rvalid`=1 in cycle 1, `m0_rdata` = preloaded 0xDEADBEEF, `m1_rvalid`=0.
- Both ports request continuously, no lock, for 6 cycles. Required grant order is 0,1,0,1,0,1, with each `rvalid` routed to the matching port.
- Port 1 writes 0xAABBCCDD with be=4'b0101, then port 0 reads the same word the next cycle. Required: write ack with `m1_rdata`=0, then `m0_rdata`=0x00BB00DD when the word was pre-zeroed.
- Port 1 holds `m1_lock` with MAX_LOCK=4 while port 0 requests continuously. Required: port 1 wins 5 cycles (1 initial + 4 locked), port 0 wins once, then port 1 resumes.
- `rst` asserted the cycle after port 0's read is accepted. Required: no `m0_rvalid`, both gnts 0 while `rst`=1, and the first tie after `rst` falls goes to port 0.
- Idle cycles with no requests. Required: `d_we`=0, `d_be`=0, and no `rvalid` pulses.
